// File: rtl/input_sequencer_if.sv
// Handshake/bus bundle for input_sequencer: button, restart and operand inputs
// plus the registered status and operand outputs.
interface input_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 2,
  parameter int STEPW   = 8
);
  localparam int CW = $clog2(NUM_OPS + 1);

  logic                     en;
  logic                     clr;
  logic [WIDTH-1:0]         din;
  logic [CW-1:0]            control;
  logic                     cap;
  logic                     op_valid;
  logic [NUM_OPS*WIDTH-1:0] ops_flat;
  logic                     step;
  logic [STEPW-1:0]         step_cnt;

  modport master (
    output en, clr, din,
    input  control, cap, op_valid, ops_flat, step, step_cnt
  );

  modport slave (
    input  en, clr, din,
    output control, cap, op_valid, ops_flat, step, step_cnt
  );
endinterface

// File: rtl/input_sequencer.sv
// Operand-entry and stepping controller driven by a synchronised push-button.
// Optional debounce filter is compiled in with INPUT_SEQUENCER_DEBOUNCE_EN.
module input_sequencer #(
  parameter int WIDTH     = 8,
  parameter int NUM_OPS   = 2,
  parameter int STEPW     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input_sequencer_if.slave   bus
);
  localparam int OPW = NUM_OPS * WIDTH;
  localparam int CW  = $clog2(NUM_OPS + 1);
  localparam logic [CW-1:0] LAST_OP = CW'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  if (NUM_OPS < 1 || NUM_OPS > 15 || DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_params
    $error("input_sequencer: parameter out of legal range");
  end

  logic en_s1_r, en_s2_r, en_last_r;
  logic en_c_s, ev_s;

  // Two-flop synchroniser and edge history; clr deliberately leaves these alone
  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1_r   <= 1'b0;
      en_s2_r   <= 1'b0;
      en_last_r <= 1'b0;
    end else begin
      en_s1_r   <= bus.en;
      en_s2_r   <= en_s1_r;
      en_last_r <= en_c_s;
    end
  end

`ifdef INPUT_SEQUENCER_DEBOUNCE_EN
  localparam logic [15:0] DB_LIMIT = 16'(DB_CYCLES);
  logic [15:0] db_cnt_r;
  logic        en_f_r;

  // Filtered level flips only after a sustained disagreement; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_r <= 16'd0;
      en_f_r   <= 1'b0;
    end else if (en_s2_r == en_f_r) begin
      db_cnt_r <= 16'd0;
    end else if (db_cnt_r == DB_LIMIT) begin
      db_cnt_r <= 16'd0;
      en_f_r   <= en_s2_r;
    end else begin
      db_cnt_r <= db_cnt_r + 16'd1;
    end
  end

  assign en_c_s = en_f_r;
`else
  assign en_c_s = en_s2_r;
`endif

  assign ev_s = en_c_s & ~en_last_r;

  state_t           state_r, state_nxt;
  logic [CW-1:0]    control_r, control_nxt;
  logic             cap_r, cap_nxt;
  logic             op_valid_r, op_valid_nxt;
  logic [OPW-1:0]   ops_r, ops_nxt;
  logic             step_r, step_nxt;
  logic [STEPW-1:0] step_cnt_r, step_cnt_nxt;

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      control_r  <= '0;
      cap_r      <= 1'b0;
      op_valid_r <= 1'b0;
      ops_r      <= '0;
      step_r     <= 1'b0;
      step_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt;
      control_r  <= control_nxt;
      cap_r      <= cap_nxt;
      op_valid_r <= op_valid_nxt;
      ops_r      <= ops_nxt;
      step_r     <= step_nxt;
      step_cnt_r <= step_cnt_nxt;
    end
  end

  // Next-state logic; clr outranks a coincident event, which is then dropped
  always_comb begin
    state_nxt    = state_r;
    control_nxt  = control_r;
    cap_nxt      = 1'b0;
    op_valid_nxt = op_valid_r;
    ops_nxt      = ops_r;
    step_nxt     = 1'b0;
    step_cnt_nxt = step_cnt_r;
    if (bus.clr) begin
      state_nxt    = IDLE;
      control_nxt  = '0;
      op_valid_nxt = 1'b0;
      ops_nxt      = '0;
      step_cnt_nxt = '0;
    end else if (ev_s) begin
      case (state_r)
        IDLE, LOAD: begin
          // control is 0 in IDLE, so one slot expression covers both states
          ops_nxt[int'(control_r)*WIDTH +: WIDTH] = bus.din;
          cap_nxt     = 1'b1;
          control_nxt = control_r + CW'(1);
          if (control_r == LAST_OP) begin
            state_nxt    = RUN;
            op_valid_nxt = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
        RUN: begin
          step_nxt     = 1'b1;
          step_cnt_nxt = step_cnt_r + STEPW'(1);
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  assign bus.control  = control_r;
  assign bus.cap      = cap_r;
  assign bus.op_valid = op_valid_r;
  assign bus.ops_flat = ops_r;
  assign bus.step     = step_r;
  assign bus.step_cnt = step_cnt_r;
endmodule

// File: tb/tb_input_sequencer.sv
// Self-checking bench for input_sequencer (default build, no debounce) using a
// press-level reference model with randomized operands, hold times and restarts.
module tb_input_sequencer;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // press-level model: operands held, steps issued
  int        m_ld;
  int        m_steps;
  logic [7:0] m_ops [N];

  input_sequencer_if #(.WIDTH(W), .NUM_OPS(N), .STEPW(SW)) bus ();

  input_sequencer #(.WIDTH(W), .NUM_OPS(N), .STEPW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ld    = 0;
    m_steps = 0;
    for (int k = 0; k < N; k++) m_ops[k] = 8'h00;
  endtask

  task automatic chk_outputs(input string tag);
    logic [15:0] exp_ops;
    exp_ops = {m_ops[1], m_ops[0]};
    chk({tag, ".control"},  64'(bus.control),  64'(m_ld));
    chk({tag, ".op_valid"}, 64'(bus.op_valid), 64'(m_ld == N));
    chk({tag, ".ops_flat"}, 64'(bus.ops_flat), 64'(exp_ops));
    chk({tag, ".step_cnt"}, 64'(bus.step_cnt), 64'(m_steps));
  endtask

  // en is already high (first sampled at the next edge); hold then release and watch pulses
  task automatic observe(input string tag, input logic [7:0] d, input int hold);
    int ncap, nstep, first;
    int exp_cap;
    ncap = 0; nstep = 0; first = -1;
    exp_cap = (m_ld < N) ? 1 : 0;
    for (int c = 0; c < hold + 4; c++) begin
      if (c == hold) begin
        @(negedge clk);
        bus.en = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.cap || bus.step) begin
        if (first < 0) first = c;
      end
      if (bus.cap) ncap++;
      if (bus.step) nstep++;
    end
    if (exp_cap == 1) begin
      m_ops[m_ld] = d;
      m_ld++;
    end else begin
      m_steps = (m_steps + 1) % (1 << SW);
    end
    chk({tag, ".cap_count"},  64'(ncap),  64'(exp_cap));
    chk({tag, ".step_count"}, 64'(nstep), 64'(1 - exp_cap));
    chk({tag, ".latency"},    64'(first), 64'(2));
    chk_outputs(tag);
  endtask

  task automatic press(input string tag, input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.din = d;
    bus.en  = 1'b1;
    observe(tag, d, hold);
  endtask

  initial begin
    logic [7:0] d;
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.clr = 1'b0;
    bus.din = 8'h00;
    model_clear();

    // reset with button held: outputs cleared, release yields one event
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cap",  64'(bus.cap),  64'd0);
    chk("reset.step", 64'(bus.step), 64'd0);
    chk_outputs("reset");
    @(negedge clk);
    rst     = 1'b0;
    bus.din = 8'h12;
    observe("rst_release", 8'h12, 4);

    press("load2", 8'h34, 5);
    chk("load.ops_flat_3412", 64'(bus.ops_flat), 64'h3412);

    // run mode with step_cnt wrap (1,2,3,0,1)
    for (int i = 0; i < 5; i++) press("run_wrap", 8'($urandom), 3 + int'($urandom_range(0, 4)));
    chk("run_wrap.step_cnt_final", 64'(bus.step_cnt), 64'd1);

    // clr coincident with an event in RUN: event discarded, held button does not retrigger
    @(negedge clk);
    bus.din = 8'hA5;
    bus.en  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    chk("clr_ev.step", 64'(bus.step), 64'd0);
    chk("clr_ev.cap",  64'(bus.cap),  64'd0);
    chk_outputs("clr_ev");
    @(negedge clk);
    bus.clr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("clr_held.no_pulse", 64'(bus.cap | bus.step), 64'd0);
    end
    @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(posedge clk);

    press("after_clr", 8'h5A, 3);
    press("long_press", 8'hC3, 50);

    // randomized presses with occasional idle restarts
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        chk_outputs("rand_clr");
        @(negedge clk);
        bus.clr = 1'b0;
      end
      d = 8'($urandom);
      press("rand", d, 3 + int'($urandom_range(0, 9)));
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
